// File: rtl/contador_6bits_ra.sv
// rtl/contador_6bits_ra.sv - 6-bit up/down counter with load, terminal value and async active-low reset
//
// Purpose:
//   General-purpose tick/sequence counter. The count range is 0..MAX_VAL.
//   Arithmetic wraps modulo (MAX_VAL+1), not modulo 2^WIDTH.
//   Priority at each rising edge is load > en > hold.
//
// Ports:
//   clk       in   1      rising-edge clock
//   rst       in   1      asynchronous reset, active-low (0 clears Q at once)
//   en        in   1      count enable
//   up_dn     in   1      1 = increment, 0 = decrement
//   load      in   1      synchronous parallel load strobe
//   load_val  in   WIDTH  value loaded when load=1; clamped to MAX_VAL
//   Q         out  WIDTH  current count, registered
//   tc        out  1      terminal count: the next edge wraps (combinational)
//
// Build option:
//   CONTADOR_SAT_EN - when defined, the counter saturates at MAX_VAL (up)
//                     and at 0 (down) instead of wrapping.

module contador_6bits_ra #(
  parameter int WIDTH   = 6,
  parameter int MAX_VAL = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc
);

  localparam logic [WIDTH-1:0] C_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] C_ZERO = '0;
  localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_q == C_MAX);
  assign w_at_zero = (r_q == C_ZERO);

  // An out-of-range load value is clamped so Q never exceeds MAX_VAL.
  assign w_load_clamped = (load_val > C_MAX) ? C_MAX : load_val;

  always_comb begin
    w_q_nxt = r_q;
    if (load) begin
      w_q_nxt = w_load_clamped;
    end else if (en) begin
      if (up_dn) begin
`ifdef CONTADOR_SAT_EN
        w_q_nxt = w_at_max ? C_MAX : (r_q + C_ONE);
`else
        w_q_nxt = w_at_max ? C_ZERO : (r_q + C_ONE);
`endif
      end else begin
`ifdef CONTADOR_SAT_EN
        w_q_nxt = w_at_zero ? C_ZERO : (r_q - C_ONE);
`else
        w_q_nxt = w_at_zero ? C_MAX : (r_q - C_ONE);
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= C_ZERO;
    end else begin
      r_q <= w_q_nxt;
    end
  end

  assign Q = r_q;

  // Gated by rst so the flag is low throughout reset even though Q==0 there.
  assign tc = rst & en & ~load & ((up_dn & w_at_max) | (~up_dn & w_at_zero));

endmodule

// File: tb/tb_contador_6bits_ra.sv
// tb/tb_contador_6bits_ra.sv - scoreboard bench for contador_6bits_ra (MAX_VAL 63 and 40 instances)

module tb_contador_6bits_ra;

`ifdef CONTADOR_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en;
  logic       up_dn;
  logic       load;
  logic [5:0] load_val;
  logic [5:0] q_a;
  logic [5:0] q_b;
  logic       tc_a;
  logic       tc_b;

  int checks = 0;
  int errors = 0;

  int m_a = 0;
  int m_b = 0;
  int sb_a[$];
  int sb_b[$];

  contador_6bits_ra #(.WIDTH(6), .MAX_VAL(63)) dut_a (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q_a), .tc(tc_a)
  );

  contador_6bits_ra #(.WIDTH(6), .MAX_VAL(40)) dut_b (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .Q(q_b), .tc(tc_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, required finish before limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int model_nxt(input int q, input int mx, input bit e,
                                   input bit u, input bit l, input int lv);
    if (l) return (lv > mx) ? mx : lv;
    if (!e) return q;
    if (u) begin
      if (SAT && q == mx) return mx;
      return (q + 1) % (mx + 1);
    end
    if (SAT && q == 0) return 0;
    return (q + mx) % (mx + 1);
  endfunction

  function automatic int model_tc(input int q, input int mx, input bit r,
                                  input bit e, input bit u, input bit l);
    if (!r || !e || l) return 0;
    if (u) return (q == mx) ? 1 : 0;
    return (q == 0) ? 1 : 0;
  endfunction

  // Drive one cycle of stimulus, check tc against the model, queue the
  // expected post-edge count and compare it once the edge has happened.
  task automatic step(input bit e, input bit u, input bit l, input int lv);
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = 6'(lv);
    #1;
    chk("tc_a", int'(tc_a), model_tc(m_a, 63, rst, e, u, l));
    chk("tc_b", int'(tc_b), model_tc(m_b, 40, rst, e, u, l));
    m_a = model_nxt(m_a, 63, e, u, l, lv);
    m_b = model_nxt(m_b, 40, e, u, l, lv);
    sb_a.push_back(m_a);
    sb_b.push_back(m_b);
    @(posedge clk);
    #1;
    if (sb_a.size() == 0 || sb_b.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      chk("q_a", int'(q_a), sb_a.pop_front());
      chk("q_b", int'(q_b), sb_b.pop_front());
    end
  endtask

  // Asynchronous reset pulse of 12 ns starting between clock edges.
  task automatic reset_pulse();
    en    = 1'b1;
    up_dn = 1'b0;
    load  = 1'b0;
    rst   = 1'b0;
    #1;
    chk("rst_async_q_a", int'(q_a), 0);
    chk("rst_async_q_b", int'(q_b), 0);
    chk("rst_tc_a", int'(tc_a), 0);
    chk("rst_tc_b", int'(tc_b), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_q_a", int'(q_a), 0);
    chk("rst_hold_tc_a", int'(tc_a), 0);
    #2;
    rst = 1'b1;
    m_a = 0;
    m_b = 0;
  endtask

  initial begin
    rst      = 1'b0;
    en       = 1'b0;
    up_dn    = 1'b1;
    load     = 1'b0;
    load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_q_a", int'(q_a), 0);
    chk("reset_q_b", int'(q_b), 0);
    chk("reset_tc_a", int'(tc_a), 0);
    rst = 1'b1;

    // Load 37, then async reset between edges.
    step(1'b0, 1'b1, 1'b1, 37);
    reset_pulse();

    // Full up-count: 65 edges, wraps at 63 (dut_a) and at 40 (dut_b).
    for (int i = 0; i < 65; i++) step(1'b1, 1'b1, 1'b0, 0);

    // Down wrap from 2.
    step(1'b0, 1'b1, 1'b1, 2);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 0);

    // Load has priority over enable; 55 clamps to 40 on dut_b.
    step(1'b1, 1'b1, 1'b1, 45);
    step(1'b1, 1'b0, 1'b1, 55);
    step(1'b0, 1'b1, 1'b1, 63);

    // Hold at 20.
    step(1'b0, 1'b1, 1'b1, 20);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 0);

    // Mid-operation reset then count up again.
    reset_pulse();
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 0);

    // Boundary behaviour at the top and bottom (wrap or saturate by build).
    step(1'b0, 1'b1, 1'b1, 62);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1'b1, 39);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 0);

    // Random mix, including direction changes on consecutive edges.
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), int'($urandom_range(0, 63)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
